icache_line_filler: RTL and testbench

//  Refill engine between the instruction cache and the memory bus. It takes the

---
 rtl/icache_line_filler_if.sv | 43 ++++
 rtl/icache_line_filler.sv | 135 +++++++++++++
 tb/tb_icache_line_filler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_line_filler_if.sv
// Refill-path bundle: I-cache request/line return plus the AXI-style read channels.
// Latency: none (wires only).
// Backpressure: AR uses ar_vld/ar_rdy, R uses r_vld/r_rdy; the cache side has none.
interface icache_line_filler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 32
);
  localparam int OFFSET_WIDTH = $clog2(DATA_WIDTH * BLOCK_SIZE / 8);
  localparam int CACHE_WIDTH  = BLOCK_SIZE * DATA_WIDTH;
  localparam int LINE_AW      = ADDR_WIDTH - OFFSET_WIDTH;

  // cache side
  logic [LINE_AW-1:0]     req_addr;
  logic                   req_vld;
  logic [CACHE_WIDTH-1:0] line_dat;
  logic                   line_vld;
  logic                   busy;
  logic                   refill_err;
  // memory read-address channel
  logic [ADDR_WIDTH-1:0]  ar_addr;
  logic [7:0]             ar_len;
  logic                   ar_vld;
  logic                   ar_rdy;
  // memory read-data channel
  logic [DATA_WIDTH-1:0]  r_dat;
  logic [1:0]             r_resp;
  logic                   r_last;
  logic                   r_vld;
  logic                   r_rdy;

  // filler side: masters the memory bus, serves the cache
  modport master (
    input  req_addr, req_vld, ar_rdy, r_dat, r_resp, r_last, r_vld,
    output line_dat, line_vld, busy, refill_err, ar_addr, ar_len, ar_vld, r_rdy
  );

  // environment side: cache plus memory
  modport slave (
    output req_addr, req_vld, ar_rdy, r_dat, r_resp, r_last, r_vld,
    input  line_dat, line_vld, busy, refill_err, ar_addr, ar_len, ar_vld, r_rdy
  );
endinterface

// File: rtl/icache_line_filler.sv
// I-cache refill engine: one read burst per miss, beats packed into a line, word 0 in the LSBs.
// Latency: request at N -> ar_vld at N+1 -> line_vld at N+2+BLOCK_SIZE with no stalls.
// Backpressure: holds AR until ar_rdy; r_rdy high throughout the burst; one refill in flight.
module icache_line_filler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  icache_line_filler_if.master  bus_io
);

  localparam int OFFSET_WIDTH = $clog2(DATA_WIDTH * BLOCK_SIZE / 8);
  localparam int CACHE_WIDTH  = BLOCK_SIZE * DATA_WIDTH;
  localparam int LINE_AW      = ADDR_WIDTH - OFFSET_WIDTH;
  // one extra bit so the counter reaches BLOCK_SIZE without wrapping
  localparam int CNT_W        = $clog2(BLOCK_SIZE) + 1;
  localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BEATS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [LINE_AW-1:0]     addr_q,  addr_d;
  logic [CACHE_WIDTH-1:0] line_q,  line_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   err_q,   err_d;

  // State and datapath registers; reset clears the line so nothing stale is visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and beat assembly; extra beats and short bursts both mark the line bad.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus_io.req_vld) begin
          addr_d  = bus_io.req_addr;
          line_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_io.ar_rdy) begin
          state_d = BEATS;
        end
      end
      BEATS: begin
        if (bus_io.r_vld) begin
          if (cnt_q < BLK_CNT) begin
            for (int w = 0; w < BLOCK_SIZE; w++) begin
              if (cnt_q == CNT_W'(w)) begin
                line_d[w*DATA_WIDTH +: DATA_WIDTH] = bus_io.r_dat;
              end
            end
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          if (bus_io.r_resp != 2'b00) begin
            err_d = 1'b1;
          end
          if (bus_io.r_last) begin
            // cnt_q counts beats before this one, so a full burst ends at BLOCK_SIZE-1
            if (cnt_q < LAST_CNT) begin
              err_d = 1'b1;
            end
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; AR fields read as zero outside REQ.
  always_comb begin
    bus_io.ar_vld     = 1'b0;
    bus_io.ar_addr    = '0;
    bus_io.ar_len     = 8'd0;
    bus_io.r_rdy      = 1'b0;
    bus_io.line_vld   = 1'b0;
    bus_io.refill_err = 1'b0;
    bus_io.busy       = (state_q != IDLE);
    bus_io.line_dat   = line_q;
    case (state_q)
      REQ: begin
        bus_io.ar_vld  = 1'b1;
        bus_io.ar_addr = {addr_q, {OFFSET_WIDTH{1'b0}}};
        bus_io.ar_len  = 8'(BLOCK_SIZE - 1);
      end
      BEATS: begin
        bus_io.r_rdy = 1'b1;
      end
      DONE: begin
        bus_io.line_vld   = 1'b1;
        bus_io.refill_err = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_icache_line_filler.sv
// Bench for icache_line_filler: randomized bursts against a line/error model built from the refill rules.
// Latency: checks AR at request+1 and line return at request+2+beats on unstalled bursts.
// Backpressure: exercises AR stalls, gapped R beats, short/long bursts and mid-burst reset.
module tb_icache_line_filler;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 32;
  localparam int OW = $clog2(DW * BS / 8);
  localparam int CW = DW * BS;
  localparam int LW = AW - OW;
  localparam int BOUND = 400;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_line_filler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

  icache_line_filler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;

  // what the last refill looked like from outside
  logic [CW-1:0] obs_line;
  logic          obs_err;
  int            obs_vld_cnt, obs_done_cyc, obs_ar_first, obs_ar_cyc;
  logic [AW-1:0] obs_ar_addr;
  logic [7:0]    obs_ar_len;
  bit            obs_ar_bad, obs_early_rrdy, obs_timeout;
  logic [5:0]    obs_rst_outs;
  bit            obs_rst_line_zero;
  // reference model result
  logic [CW-1:0] exp_line;
  logic          exp_err;

  task automatic idle_inputs();
    bus.req_vld = 1'b0; bus.req_addr = '0; bus.ar_rdy = 1'b0;
    bus.r_vld = 1'b0; bus.r_dat = '0; bus.r_resp = 2'b00; bus.r_last = 1'b0;
  endtask

  // Drives one refill; vmode 0 = continuous beats, 1 = alternate, 2 = random gaps.
  task automatic refill(input logic [LW-1:0] line, input int ar_wait, input int nbeats,
                        input int vmode, input int bad_beat, input bit seq_data, input int abort_at);
    logic [DW-1:0] sent[$];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] cur_dat;
    logic [1:0]    cur_resp;
    bit any_bad, ar_done, have_beat, presenting, rrdy_prev, vphase, finished;
    int cyc, tail;
    exp_addr = {line, {OW{1'b0}}};
    obs_line = '0; obs_err = 1'b0; obs_vld_cnt = 0; obs_done_cyc = -1;
    obs_ar_first = -1; obs_ar_cyc = 0; obs_ar_addr = '0; obs_ar_len = '0;
    obs_ar_bad = 0; obs_early_rrdy = 0; obs_timeout = 0;
    obs_rst_outs = '0; obs_rst_line_zero = 1;
    any_bad = 0; ar_done = 0; have_beat = 0; presenting = 0; rrdy_prev = 0;
    vphase = 1; finished = 0; cyc = 0; tail = 0;
    cur_dat = '0; cur_resp = 2'b00;
    @(negedge clk);
    bus.req_addr = line; bus.req_vld = 1'b1;
    while (!finished && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      bus.req_vld = 1'b0;
      if (bus.line_vld) begin
        obs_vld_cnt++; obs_line = bus.line_dat; obs_err = bus.refill_err; obs_done_cyc = cyc;
      end
      if (presenting && rrdy_prev) begin
        sent.push_back(cur_dat);
        if (cur_resp != 2'b00) any_bad = 1;
        have_beat = 0;
      end
      if (abort_at >= 0 && ar_done && sent.size() == abort_at) begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        obs_rst_outs = {bus.busy, bus.line_vld, bus.r_rdy, bus.ar_vld, bus.refill_err, |bus.ar_len};
        obs_rst_line_zero = (bus.line_dat == '0);
        repeat (3) begin
          @(negedge clk);
          if (bus.line_vld) obs_vld_cnt++;
        end
        finished = 1;
      end else if (!ar_done) begin
        if (bus.ar_vld) begin
          if (obs_ar_first < 0) begin
            obs_ar_first = cyc; obs_ar_addr = bus.ar_addr; obs_ar_len = bus.ar_len;
          end
          obs_ar_cyc++;
          if (bus.ar_addr !== exp_addr || bus.ar_len !== 8'(BS - 1)) obs_ar_bad = 1;
        end else if (obs_ar_first >= 0) begin
          obs_ar_bad = 1;
        end
        if (bus.r_rdy) obs_early_rrdy = 1;
        bus.ar_rdy = bus.ar_vld && (obs_ar_cyc > ar_wait);
        if (bus.ar_rdy) ar_done = 1;
        presenting = 0;
      end else begin
        bus.ar_rdy = 1'b0;
        if (sent.size() < nbeats && obs_vld_cnt == 0) begin
          if (!have_beat) begin
            cur_dat   = seq_data ? DW'(sent.size()) : $urandom;
            cur_resp  = (sent.size() == bad_beat) ? 2'(1 + $urandom_range(0, 2)) : 2'b00;
            have_beat = 1;
          end
          case (vmode)
            1:       bus.r_vld = vphase;
            2:       bus.r_vld = ($urandom_range(0, 2) != 0);
            default: bus.r_vld = 1'b1;
          endcase
          vphase = ~vphase;
          bus.r_dat  = bus.r_vld ? cur_dat : DW'($urandom);
          bus.r_resp = bus.r_vld ? cur_resp : 2'b00;
          bus.r_last = bus.r_vld && (sent.size() == nbeats - 1);
        end else begin
          bus.r_vld = 1'b0; bus.r_last = 1'b0; bus.r_resp = 2'b00;
        end
        presenting = bus.r_vld;
        rrdy_prev  = bus.r_rdy;
        if (obs_vld_cnt > 0) begin
          tail++;
          if (tail >= 4) finished = 1;
        end
      end
    end
    if (!finished) obs_timeout = 1;
    idle_inputs();
    // model: first BS beats fill the line from word 0, missing words are zero;
    // the line is bad when the beat count differs from BS or any beat was not OKAY
    exp_line = '0;
    for (int i = 0; i < BS; i++) begin
      if (i < sent.size()) exp_line[i*DW +: DW] = sent[i];
    end
    exp_err = any_bad || (sent.size() != BS);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.line_vld, bus.refill_err, bus.ar_vld, bus.r_rdy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {bus.busy, bus.line_vld, bus.refill_err, bus.ar_vld, bus.r_rdy});
    end
    checks++;
    if (bus.line_dat !== '0) begin errors++; $display("FAIL reset_line got %h exp 0", bus.line_dat); end
    checks++;
    if (bus.ar_addr !== '0 || bus.ar_len !== '0) begin
      errors++; $display("FAIL reset_ar got %h/%h exp 0/0", bus.ar_addr, bus.ar_len);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_basic();
    logic [LW-1:0] line;
    line = LW'(32'h40);
    refill(line, 0, BS, 0, -1, 1, -1);
    checks++; if (obs_timeout) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
    checks++; if (obs_ar_first != 1) begin errors++; $display("FAIL basic_ar_lat got %0d exp 1", obs_ar_first); end
    checks++; if (obs_ar_addr !== {line, {OW{1'b0}}}) begin errors++; $display("FAIL basic_araddr got %h exp %h", obs_ar_addr, {line, {OW{1'b0}}}); end
    checks++; if (obs_ar_len !== 8'd31) begin errors++; $display("FAIL basic_arlen got %0d exp 31", obs_ar_len); end
    checks++; if (obs_done_cyc != BS + 2) begin errors++; $display("FAIL basic_done_lat got %0d exp %0d", obs_done_cyc, BS + 2); end
    checks++; if (obs_vld_cnt != 1) begin errors++; $display("FAIL basic_vld_cnt got %0d exp 1", obs_vld_cnt); end
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL basic_line got %h exp %h", obs_line, exp_line); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", obs_err); end
    checks++; if (bus.line_dat !== exp_line || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_hold got busy %b line %h exp busy 0 line %h", bus.busy, bus.line_dat, exp_line);
    end
  endtask

  task automatic test_ar_stall();
    refill(LW'($urandom), 5, BS, 0, -1, 0, -1);
    checks++; if (obs_timeout) begin errors++; $display("FAIL stall_timeout got 1 exp 0"); end
    checks++; if (obs_ar_cyc != 6) begin errors++; $display("FAIL stall_ar_cycles got %0d exp 6", obs_ar_cyc); end
    checks++; if (obs_ar_bad) begin errors++; $display("FAIL stall_ar_stable got unstable exp stable"); end
    checks++; if (obs_early_rrdy) begin errors++; $display("FAIL stall_early_rrdy got 1 exp 0"); end
    checks++; if (obs_line !== exp_line || obs_vld_cnt != 1) begin
      errors++; $display("FAIL stall_line got %h (%0d pulses) exp %h", obs_line, obs_vld_cnt, exp_line);
    end
  endtask

  task automatic test_rvalid_toggle();
    refill(LW'($urandom), 0, BS, 1, -1, 0, -1);
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL toggle_line got %h exp %h", obs_line, exp_line); end
    checks++; if (obs_err !== 1'b0 || obs_vld_cnt != 1) begin
      errors++; $display("FAIL toggle_err got err %b pulses %0d exp 0/1", obs_err, obs_vld_cnt);
    end
    checks++; if (obs_done_cyc != 2 * BS + 1) begin errors++; $display("FAIL toggle_done_lat got %0d exp %0d", obs_done_cyc, 2 * BS + 1); end
  endtask

  task automatic test_short_burst();
    refill(LW'($urandom), 0, 10, 0, -1, 0, -1);
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL short_line got %h exp %h", obs_line, exp_line); end
    checks++; if ((obs_line >> (10 * DW)) !== '0) begin errors++; $display("FAIL short_upper got %h exp 0", obs_line >> (10 * DW)); end
    checks++; if (obs_err !== 1'b1 || obs_vld_cnt != 1) begin
      errors++; $display("FAIL short_err got err %b pulses %0d exp 1/1", obs_err, obs_vld_cnt);
    end
    checks++; if (obs_done_cyc != 12) begin errors++; $display("FAIL short_done_lat got %0d exp 12", obs_done_cyc); end
  endtask

  task automatic test_bad_resp();
    refill(LW'($urandom), 0, BS, 0, 7, 0, -1);
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL bresp_line got %h exp %h", obs_line, exp_line); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL bresp_err got %b exp 1", obs_err); end
    refill(LW'($urandom), 0, BS, 0, -1, 0, -1);
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL bresp_next_err got %b exp 0", obs_err); end
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL bresp_next_line got %h exp %h", obs_line, exp_line); end
  endtask

  task automatic test_overrun();
    refill(LW'($urandom), 0, BS + 2, 0, -1, 0, -1);
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL over_line got %h exp %h", obs_line, exp_line); end
    checks++; if (obs_err !== 1'b1 || obs_vld_cnt != 1) begin
      errors++; $display("FAIL over_err got err %b pulses %0d exp 1/1", obs_err, obs_vld_cnt);
    end
    checks++; if (obs_done_cyc != BS + 4) begin errors++; $display("FAIL over_done_lat got %0d exp %0d", obs_done_cyc, BS + 4); end
  endtask

  task automatic test_reset_abort();
    refill(LW'($urandom), 0, BS, 0, -1, 0, 15);
    checks++; if (obs_rst_outs !== 6'b0) begin errors++; $display("FAIL abort_outs got %b exp 000000", obs_rst_outs); end
    checks++; if (!obs_rst_line_zero) begin errors++; $display("FAIL abort_line got nonzero exp 0"); end
    checks++; if (obs_vld_cnt != 0) begin errors++; $display("FAIL abort_vld got %0d exp 0", obs_vld_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    refill(LW'($urandom), 0, BS, 0, -1, 0, -1);
    checks++; if (obs_line !== exp_line || obs_err !== 1'b0) begin
      errors++; $display("FAIL abort_next got %h err %b exp %h err 0", obs_line, obs_err, exp_line);
    end
    checks++; if (obs_vld_cnt != 1) begin errors++; $display("FAIL abort_next_vld got %0d exp 1", obs_vld_cnt); end
  endtask

  task automatic test_random();
    int nb, bad;
    for (int it = 0; it < 10; it++) begin
      nb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, BS + 3)) : BS;
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      refill(LW'($urandom), int'($urandom_range(0, 3)), nb, int'($urandom_range(0, 2)), bad, 0, -1);
      checks++; if (obs_timeout || obs_vld_cnt != 1) begin
        errors++; $display("FAIL rand%0d_pulses got %0d timeout %b exp 1/0", it, obs_vld_cnt, obs_timeout);
      end
      checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL rand%0d_line got %h exp %h", it, obs_line, exp_line); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rand%0d_err got %b exp %b", it, obs_err, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_rvalid_toggle();
    test_short_burst();
    test_bad_resp();
    test_overrun();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
